onehot_rr_scheduler: RTL and testbench
======================================

# onehot_rr_scheduler

Round-robin scheduler that shares one start/done processing engine (one-hot IDLE→LOAD→PROCESS→DONE sequencer) among N requesters. It picks one pending requester and holds a one-hot grant. It pulses the engine's start, waits for the engine's done pulse, then returns a one-cycle ack to the winner. A watchdog ends a job that never completes and flags an error. The block sits between the requester clients and the single engine instance, and drives the engine's start input.

## Interface
- N, default 4: number of requesters (2..16).
- TIMEOUT, default 8: maximum WAIT cycles before the job is force-terminated (≥4).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; the engine shares this reset.
- req  in  N  per-requester job request, level; held until the matching ack.
- eng_done  in  1  engine done, high for one cycle when the engine is in its DONE state.
- eng_start  out  1  one-cycle start pulse to the engine.
- grant  out  N  one-hot owner of the engine; all-zero when idle.
- ack  out  N  one-hot, one-cycle job-complete pulse to the granted requester.
- timeout_err  out  1  one-cycle pulse, coincident with ack, when the job timed out.
- busy  out  1  high in every state except S_IDLE.
- ctrl_state  out  4  one-hot controller state (for debug and verification).

## Operation
- One-hot states: S_IDLE=4'b0001, S_ISSUE=4'b0010, S_WAIT=4'b0100, S_ACK=4'b1000.
- Outputs are decoded from the registered state and registered grant/err; no combinational path runs from req or eng_done to any output.
- S_IDLE:
  - If req≠0, select the winner by round-robin: search index ptr, ptr+1, …, wrapping N-1→0; the first set req bit wins.
  - Register grant = one-hot(winner), clear the timeout counter and error flag, go to S_ISSUE.
  - If req=0, stay in S_IDLE.
- S_ISSUE: eng_start=1 for this single cycle; go to S_WAIT.
- S_WAIT:
  - If eng_done=1, go to S_ACK with err=0.
  - Otherwise increment the counter. If the counter equals TIMEOUT-1 in this cycle, go to S_ACK with err=1; otherwise stay.
  - eng_done and the timeout in the same cycle: done wins, err=0.
- S_ACK:
  - ack = grant for one cycle; timeout_err = err.
  - ptr ← (winner+1) mod N; at winner=N-1, ptr wraps to 0.
  - Clear grant on exit; go to S_IDLE.
- Counter width is clog2(TIMEOUT+1) and it saturates; it never wraps.
- req is sampled only in S_IDLE. Deasserting a granted req mid-job does not abort the job; ack still pulses. req changes while busy are ignored.
- eng_done outside S_WAIT is ignored.
- Any non-one-hot state goes to S_IDLE on the next edge with grant cleared.
- Reset, including mid-job, forces:
  - state=S_IDLE, grant=0, ptr=0, counter=0, err=0;
  - outputs eng_start=0, ack=0, timeout_err=0, busy=0, ctrl_state=4'b0001.
  - The interrupted requester receives no ack.

## Timing
- Cycle 0 is S_IDLE with req sampled. Cycle 1 is S_ISSUE (eng_start high). WAIT starts at cycle 2.
- With the standard engine (3-cycle start→done):
  - the engine is in LOAD at c2, PROCESS at c3, and DONE (eng_done high) at c4;
  - the controller is in S_ACK with ack high at c5 and back in S_IDLE at c6;
  - grant is valid c1–c5.
- Back-to-back requests give one job every 6 cycles. The next eng_start arrives at c7, and the engine has been in IDLE since c5.
- Timeout path: S_WAIT lasts exactly TIMEOUT cycles. ack and timeout_err fire at cycle 2+TIMEOUT.

## Test plan
- Single request: req=4'b0100 from reset.
  - grant=0100 on c1–c5; eng_start high on c1 only; ack=0100 on c5 only; timeout_err=0.
  - ptr becomes 3.
- Round-robin fairness: req=4'b1111 held, reasserting each bit after its ack.
  - Grants go 0001, 0010, 0100, 1000, 0001, i.e. the wrap at N-1.
  - eng_start occurs every 6 cycles.
- Priority from ptr: after a job for requester 2, assert req=4'b0101. Requester 0 is granted first, then requester 2.
- Timeout: TIMEOUT=8, eng_done held 0.
  - S_WAIT lasts 8 cycles; ack and timeout_err pulse together at c10; grant clears at c11.
  - A done arriving in the final WAIT cycle gives timeout_err=0.
- Stray done and withdrawn request:
  - eng_done pulses while in S_IDLE: no state change.
  - req drops at c3: ack still pulses at c5.
- Reset mid-job: assert rst during S_WAIT.
  - All outputs go to 0 immediately, ctrl_state=0001, no ack is issued.
  - After release, req=0001 restarts normally with ptr=0.

Source files
------------

// File: rtl/onehot_rr_scheduler.sv
// Round-robin scheduler sharing one start/done engine among N requesters.
// One-hot controller with a saturating watchdog that force-completes hung jobs.
module onehot_rr_scheduler #(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         eng_done,
  output logic         eng_start,
  output logic [N-1:0] grant,
  output logic [N-1:0] ack,
  output logic         timeout_err,
  output logic         busy,
  output logic [3:0]   ctrl_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_ISSUE = 4'b0010;
  localparam logic [3:0] S_WAIT  = 4'b0100;
  localparam logic [3:0] S_ACK   = 4'b1000;

  logic [3:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] win_q, win_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Search ptr, ptr+1, ... wrapping at N-1; first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
          win_d   = win_idx;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_d = S_ACK;
          err_d   = 1'b0;
        end else begin
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
          // Registered count equals the number of WAIT cycles already spent.
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d = S_ACK;
            err_d   = 1'b1;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    eng_start   = (state_q == S_ISSUE);
    grant       = grant_q;
    ack         = (state_q == S_ACK) ? grant_q : '0;
    timeout_err = (state_q == S_ACK) && err_q;
    busy        = (state_q != S_IDLE);
    ctrl_state  = state_q;
  end

endmodule

// File: tb/tb_onehot_rr_scheduler.sv
// Directed self-checking bench for onehot_rr_scheduler (N=4, TIMEOUT=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_onehot_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       eng_done;
  logic       eng_start;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       timeout_err;
  logic       busy;
  logic [3:0] ctrl_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc;
  int prev_start;

  onehot_rr_scheduler #(.N(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .eng_done(eng_done),
    .eng_start(eng_start), .grant(grant), .ack(ack),
    .timeout_err(timeout_err), .busy(busy), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".state"}, 32'(ctrl_state), 32'h1);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".ack"}, 32'(ack), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".start"}, 32'(eng_start), 32'h0);
    chk({tag, ".terr"}, 32'(timeout_err), 32'h0);
  endtask

  // Standard 3-cycle engine job from S_IDLE; leaves the bench at c6 (S_IDLE).
  task automatic run_job(input string tag, input logic [3:0] r, input logic [3:0] g);
    req = r;
    chk({tag, ".c0_state"}, 32'(ctrl_state), 32'h1);
    step();
    start_cyc = cyc;
    chk({tag, ".c1_state"}, 32'(ctrl_state), 32'h2);
    chk({tag, ".c1_start"}, 32'(eng_start), 32'h1);
    chk({tag, ".c1_grant"}, 32'(grant), 32'(g));
    step();
    chk({tag, ".c2_state"}, 32'(ctrl_state), 32'h4);
    chk({tag, ".c2_start"}, 32'(eng_start), 32'h0);
    step();
    chk({tag, ".c3_grant"}, 32'(grant), 32'(g));
    step();
    eng_done = 1'b1;
    chk({tag, ".c4_ack"}, 32'(ack), 32'h0);
    step();
    eng_done = 1'b0;
    chk({tag, ".c5_state"}, 32'(ctrl_state), 32'h8);
    chk({tag, ".c5_ack"}, 32'(ack), 32'(g));
    chk({tag, ".c5_grant"}, 32'(grant), 32'(g));
    chk({tag, ".c5_terr"}, 32'(timeout_err), 32'h0);
    req = r & ~g;
    step();
    chk_idle({tag, ".c6"});
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    rst = 1'b1; req = '0; eng_done = 1'b0;
    step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    // Fairness: all four requesting, each reasserted after its ack.
    prev_start = 0;
    for (int k = 0; k < 5; k++) begin
      run_job($sformatf("rr%0d", k), 4'b1111, rr_exp[k]);
      if (k > 0) chk($sformatf("rr%0d.spacing", k), 32'(start_cyc - prev_start), 32'd6);
      prev_start = start_cyc;
    end

    // Single request for 2 (ptr was 1); then ptr=3 so 0 beats 2.
    run_job("single2", 4'b0100, 4'b0100);
    run_job("prio0", 4'b0101, 4'b0001);
    run_job("prio2", 4'b0100, 4'b0100);

    // Timeout: engine never answers.
    req = 4'b0100;
    step();
    chk("to.c1_start", 32'(eng_start), 32'h1);
    for (int c = 2; c <= 9; c++) begin
      step();
      chk($sformatf("to.c%0d_wait", c), 32'(ctrl_state), 32'h4);
    end
    step();
    req = 4'b0000;
    chk("to.c10_state", 32'(ctrl_state), 32'h8);
    chk("to.c10_ack", 32'(ack), 32'h4);
    chk("to.c10_terr", 32'(timeout_err), 32'h1);
    step();
    chk_idle("to.c11");

    // Done in the final WAIT cycle beats the timeout.
    req = 4'b0100;
    step(); step();
    for (int c = 3; c <= 9; c++) step();
    chk("late.c9_wait", 32'(ctrl_state), 32'h4);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    req = 4'b0000;
    chk("late.c10_ack", 32'(ack), 32'h4);
    chk("late.c10_terr", 32'(timeout_err), 32'h0);
    step();
    chk_idle("late.c11");

    // Stray done while idle.
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk_idle("stray");
    step();
    chk_idle("stray2");

    // Request withdrawn at c3 still completes.
    req = 4'b0100;
    step(); step(); step();
    req = 4'b0000;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("wd.c5_ack", 32'(ack), 32'h4);
    step();
    chk_idle("wd.c6");

    // Reset during WAIT (ptr is 3 here); no ack, ptr back to 0.
    req = 4'b0100;
    step(); step(); step();
    chk("rst.c3_wait", 32'(ctrl_state), 32'h4);
    rst = 1'b1;
    #1;
    chk_idle("rst.async");
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst.hold%0d_ack", c), 32'(ack), 32'h0);
    end
    rst = 1'b0;
    step();
    chk_idle("rst.release");
    run_job("after_rst", 4'b1001, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
